mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Synchronous two-master arbiter and sequencer for the single unified memory port of the multi-cycle MIPS32 core. It shares the memory between the CPU (instruction fetch and load/store) and a loader/debug master that preloads programs and inspects memory. It serialises accesses, drives the memory strobes for exactly one owner at a time, and returns a one-cycle acknowledge with captured read data. A watchdog aborts any access whose memory never signals ready.

## Interface
Parameters:
- WIDTH, 32, address and data width.
- TIMEOUT, 15, maximum number of ACCESS cycles to wait for mem_ready before aborting; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- cpu_req  in  1  CPU requests an access. Held high with stable fields until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  WIDTH  CPU byte address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  WIDTH  read data. Valid in the cpu_ack cycle and held until the next CPU read completes.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/WIDTH/WIDTH  loader master; same rules as the CPU signals.
- ldr_ack, ldr_rdata  out  1/WIDTH  loader completion pulse and read data; same rules as the CPU signals.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data; 0 unless mem_write is high.
- mem_rdata  in  WIDTH  memory read data; sampled when mem_ready is high.
- mem_ready  in  1  memory has completed the current strobe.
- owner  out  1  current or most recent grant: 0 = CPU, 1 = loader.
- err  out  1  one-cycle pulse, coincident with ack, when an access timed out.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any req is high, pick a winner and register its we/addr/wdata. Go to ACCESS.
  - If no req is high, stay in IDLE.
- **Arbitration** is round-robin on the last owner.
  - If both requests are high, grant the master that is not `owner`.
  - If only one request is high, grant it.
  - `owner` updates on grant.
- **ACCESS**
  - mem_read = !we and mem_write = we, both registered.
  - mem_addr and mem_wdata come from the registered copies and stay stable for the whole state.
  - A wait counter increments each ACCESS cycle.
  - mem_ready high: capture mem_rdata into the winner's rdata register (reads only) and go to RESP.
  - Counter reaches TIMEOUT with mem_ready still low: go to RESP with err flagged, and leave rdata unchanged.
- **RESP**
  - Both strobes are low.
  - The winner's ack = 1, and err = 1 if the access was aborted.
  - The next state is always IDLE. Requests are ignored in RESP.
- Requester inputs are used only at grant. If a requester drops req mid-access, the access still completes and ack still pulses.
- mem_ready is ignored outside ACCESS.
- The non-owner's ack and rdata are never disturbed.

## Timing
- Reset values:
  - state = IDLE, owner = 1 (so the CPU wins the first tie).
  - mem_read, mem_write, cpu_ack, ldr_ack and err = 0.
  - mem_addr, mem_wdata, cpu_rdata, ldr_rdata and the wait counter = 0.
- Latency, with req sampled high in IDLE at edge N:
  - Strobes are high from cycle N+1.
  - If mem_ready is first high at edge M (M ≥ N+1), ack is high in cycle M+1.
  - Minimum request-to-ack latency is 2 cycles.
  - Maximum is TIMEOUT+1 cycles, with err.
- Throughput: at most one access per 3 cycles. The RESP cycle is a mandatory bus-idle cycle.
- A master that still holds req in the cycle after its ack is treated as a new request.
- Reset mid-access: in the cycle after rst is sampled, all outputs take their reset values. No ack is produced for the aborted access.

## Test plan
- **Single CPU read:** cpu_req=1, we=0, addr=0x40; memory returns 0x1234ABCD with mem_ready in the first ACCESS cycle -> mem_read high for 1 cycle with mem_addr=0x40; cpu_ack pulses 2 cycles after the request; cpu_rdata=0x1234ABCD and holds.
- **Loader write with 3-cycle wait:** ldr_we=1, addr=0x100, wdata=0xDEADBEEF; mem_ready on the 3rd ACCESS cycle -> mem_write high for 3 cycles with stable addr/wdata; ldr_ack at cycle 4; owner=1; cpu_rdata unchanged.
- **Contention:** both req high continuously from reset with zero-wait memory -> grants CPU, LDR, CPU, LDR; an ack every 3 cycles; never two acks in one cycle; strobes low in every RESP cycle.
- **Timeout:** CPU read with mem_ready held low and TIMEOUT=15 -> mem_read high for exactly 15 cycles; cpu_ack and err pulse together; cpu_rdata keeps its previous value.
- **Reset mid-access:** rst asserted in the 2nd ACCESS cycle of a loader read -> next cycle: strobes low, no ack, owner=1; a CPU request issued after reset release is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master (CPU / loader) arbiter and sequencer for a single memory port.
// Round-robin grant, registered strobes, one-cycle ack and an access watchdog.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             ldr_req,
    input  logic             ldr_we,
    input  logic [WIDTH-1:0] ldr_addr,
    input  logic [WIDTH-1:0] ldr_wdata,
    output logic             ldr_ack,
    output logic [WIDTH-1:0] ldr_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             owner,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       grant_ldr;
    logic       grant_we;

    // On a tie the master that did not win last time gets the port.
    always_comb begin
        grant_ldr = (cpu_req && ldr_req) ? ~owner : ldr_req;
        grant_we  = grant_ldr ? ldr_we : cpu_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            err       <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || ldr_req) begin
                        owner     <= grant_ldr;
                        mem_read  <= ~grant_we;
                        mem_write <= grant_we;
                        mem_addr  <= grant_ldr ? ldr_addr : cpu_addr;
                        mem_wdata <= grant_we ? (grant_ldr ? ldr_wdata : cpu_wdata) : '0;
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready || wait_cnt == LAST_WAIT) begin
                        // Read data is only captured on a real completion, not on abort.
                        if (mem_ready && mem_read) begin
                            if (owner) ldr_rdata <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        mem_wdata <= '0;
                        cpu_ack   <= ~owner;
                        ldr_ack   <= owner;
                        err       <= ~mem_ready;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change and outputs
// are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             cpu_req, cpu_we, ldr_req, ldr_we;
    logic [WIDTH-1:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic             cpu_ack, ldr_ack;
    logic [WIDTH-1:0] cpu_rdata, ldr_rdata;
    logic             mem_read, mem_write, mem_ready;
    logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
    logic             owner, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .err(err)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        step(); step();
        total++;
        if ({mem_read, mem_write, cpu_ack, ldr_ack, err} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl got=%b want=00000",
                            {mem_read, mem_write, cpu_ack, ldr_ack, err});
        end
        total++;
        if (owner !== 1'b1) begin bad++; $display("FAIL reset_owner got=%b want=1", owner); end
        total++;
        if ({mem_addr, mem_wdata, cpu_rdata, ldr_rdata} !== '0) begin
            bad++; $display("FAIL reset_data got=%h %h %h %h want=0",
                            mem_addr, mem_wdata, cpu_rdata, ldr_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        mem_ready = 1; mem_rdata = 32'h1234ABCD;
        step();
        total++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h40 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL rd_access rd=%b wr=%b addr=%h ack=%b want 1 0 40 0",
                            mem_read, mem_write, mem_addr, cpu_ack);
        end
        step();
        total++;
        if (cpu_ack !== 1'b1 || mem_read !== 1'b0 || err !== 1'b0 || ldr_ack !== 1'b0) begin
            bad++; $display("FAIL rd_ack ack=%b rd=%b err=%b lack=%b want 1 0 0 0",
                            cpu_ack, mem_read, err, ldr_ack);
        end
        total++;
        if (cpu_rdata !== 32'h1234ABCD) begin
            bad++; $display("FAIL rd_data got=%h want=1234abcd", cpu_rdata);
        end
        cpu_req = 0;
        step();
        mem_ready = 0;
        total++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 32'h1234ABCD || owner !== 1'b0) begin
            bad++; $display("FAIL rd_hold ack=%b data=%h owner=%b want 0 1234abcd 0",
                            cpu_ack, cpu_rdata, owner);
        end
    endtask

    task automatic test_ldr_write();
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h100; ldr_wdata = 32'hDEADBEEF;
        mem_ready = 0;
        for (int c = 1; c <= 3; c++) begin
            step();
            ldr_req = 0;  // dropping req mid-access must not cancel it
            if (c == 3) mem_ready = 1;
            total++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h100 ||
                mem_wdata !== 32'hDEADBEEF || ldr_ack !== 1'b0) begin
                bad++; $display("FAIL wr_access c=%0d wr=%b rd=%b addr=%h wd=%h ack=%b", c,
                                mem_write, mem_read, mem_addr, mem_wdata, ldr_ack);
            end
        end
        step();
        mem_ready = 0;
        total++;
        if (ldr_ack !== 1'b1 || cpu_ack !== 1'b0 || owner !== 1'b1 || mem_write !== 1'b0 ||
            mem_wdata !== 32'h0) begin
            bad++; $display("FAIL wr_ack ack=%b cack=%b owner=%b wr=%b wd=%h want 1 0 1 0 0",
                            ldr_ack, cpu_ack, owner, mem_write, mem_wdata);
        end
        total++;
        if (cpu_rdata !== 32'h1234ABCD || ldr_rdata !== 32'h0) begin
            bad++; $display("FAIL wr_rdata cpu=%h ldr=%h want 1234abcd 0", cpu_rdata, ldr_rdata);
        end
        step();
    endtask

    task automatic test_contention();
        int  ack_cnt = 0;
        logic exp_cpu, exp_ldr, exp_strobe;
        rst = 1; step(); rst = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h80;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h84;
        mem_ready = 1; mem_rdata = 32'h5555AAAA;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 11) begin cpu_req = 0; ldr_req = 0; end
            exp_strobe = (k % 3 == 0);
            exp_cpu    = (k % 3 == 1) && ((k / 3) % 2 == 0);
            exp_ldr    = (k % 3 == 1) && ((k / 3) % 2 == 1);
            total++;
            if (cpu_ack !== exp_cpu || ldr_ack !== exp_ldr || mem_read !== exp_strobe ||
                mem_write !== 1'b0) begin
                bad++; $display("FAIL contend k=%0d cack=%b lack=%b rd=%b wr=%b want %b %b %b 0",
                                k, cpu_ack, ldr_ack, mem_read, mem_write,
                                exp_cpu, exp_ldr, exp_strobe);
            end
            if (cpu_ack === 1'b1 || ldr_ack === 1'b1) ack_cnt++;
        end
        mem_ready = 0;
        total++;
        if (ack_cnt != 4 || owner !== 1'b1) begin
            bad++; $display("FAIL contend_sum acks=%0d owner=%b want 4 1", ack_cnt, owner);
        end
        total++;
        if (cpu_rdata !== 32'h5555AAAA || ldr_rdata !== 32'h5555AAAA) begin
            bad++; $display("FAIL contend_data cpu=%h ldr=%h want 5555aaaa", cpu_rdata, ldr_rdata);
        end
    endtask

    task automatic test_timeout();
        int  rd_cycles = 0;
        int  ack_at    = -1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC0;
        mem_ready = 0; mem_rdata = 32'hFFFF0000;
        for (int c = 1; c <= 40 && ack_at < 0; c++) begin
            step();
            if (mem_read === 1'b1) rd_cycles++;
            if (cpu_ack === 1'b1) begin
                ack_at  = c;
                cpu_req = 0;
                total++;
                if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err); end
            end else if (err === 1'b1) begin
                total++; bad++; $display("FAIL to_err_early c=%0d got=1 want=0", c);
            end
        end
        cpu_req = 0;
        total++;
        if (ack_at != TIMEOUT + 1) begin
            bad++; $display("FAIL to_latency got=%0d want=%0d", ack_at, TIMEOUT + 1);
        end
        total++;
        if (rd_cycles != TIMEOUT) begin
            bad++; $display("FAIL to_strobe got=%0d want=%0d", rd_cycles, TIMEOUT);
        end
        total++;
        if (cpu_rdata !== 32'h5555AAAA) begin
            bad++; $display("FAIL to_rdata got=%h want=5555aaaa", cpu_rdata);
        end
        step();
        total++;
        if (err !== 1'b0 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL to_clear err=%b ack=%b want 0 0", err, cpu_ack);
        end
    endtask

    task automatic test_reset_mid();
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h200; mem_ready = 0;
        step();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h200) begin
            bad++; $display("FAIL rm_access rd=%b addr=%h want 1 200", mem_read, mem_addr);
        end
        step();
        rst = 1; ldr_req = 0;
        step();
        rst = 0;
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || ldr_ack !== 1'b0 || cpu_ack !== 1'b0 ||
            err !== 1'b0 || owner !== 1'b1 || mem_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
            bad++; $display("FAIL rm_reset rd=%b wr=%b la=%b ca=%b err=%b own=%b addr=%h cd=%h",
                            mem_read, mem_write, ldr_ack, cpu_ack, err, owner, mem_addr, cpu_rdata);
        end
        step();
        total++;
        if (ldr_ack !== 1'b0 || mem_read !== 1'b0) begin
            bad++; $display("FAIL rm_noack ack=%b rd=%b want 0 0", ldr_ack, mem_read);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44; mem_ready = 1; mem_rdata = 32'h0BADF00D;
        step();
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h44 || owner !== 1'b0) begin
            bad++; $display("FAIL rm_cpu_grant rd=%b addr=%h own=%b want 1 44 0",
                            mem_read, mem_addr, owner);
        end
        step();
        cpu_req = 0; mem_ready = 0;
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h0BADF00D || err !== 1'b0) begin
            bad++; $display("FAIL rm_cpu_ack ack=%b data=%h err=%b want 1 0badf00d 0",
                            cpu_ack, cpu_rdata, err);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_contention();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
